// File: rtl/vend_coin_frontend_pkg.sv
// Shared definitions for the vending-machine coin/accept front end:
// emitter state encoding and default parameter values.
package vend_coin_frontend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } emit_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_PULSE_GAP       = 2;
  localparam int DEF_MAX_PENDING     = 7;

endpackage

// File: rtl/vend_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw level input.
// Emits a one-cycle strobe when the debounced level goes 0->1.
module vend_debounce
  import vend_coin_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // The flip happens on the cycle after the counter has reached the limit,
  // so a level held from edge k is stable at edge k+2+DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        stable <= sync2;
        cnt    <= '0;
        rise   <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_coin_frontend.sv
// Customer-side front end: debounced coin/accept inputs, a coin credit queue,
// and a paced emitter producing single-cycle m/a strobes for the vending FSM.
//
// state    | meaning
// ST_IDLE  | waiting; emits a coin (priority) or accept strobe when ena && !fsm_busy
// ST_PULSE | strobe is high this cycle; next cycle it drops
// ST_GAP   | forced idle spacing before the next strobe may be issued
module vend_coin_frontend
  import vend_coin_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_GAP       = DEF_PULSE_GAP,
  parameter int MAX_PENDING     = DEF_MAX_PENDING
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       coin_raw,
  input  logic       accept_raw,
  input  logic       fsm_busy,
  output logic       coin_pulse,
  output logic       accept_pulse,
  output logic [2:0] pending,
  output logic       overflow
);

  // PULSE itself is the first idle cycle, so GAP covers the remaining PULSE_GAP-1.
  localparam int            GW       = (PULSE_GAP > 2) ? $clog2(PULSE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((PULSE_GAP > 1) ? PULSE_GAP - 2 : 0);
  localparam logic [2:0]    PEND_MAX = 3'(MAX_PENDING);

  emit_state_t   state;
  logic [GW-1:0] gap_cnt;
  logic          accept_req;
  logic          coin_rise;
  logic          accept_rise;
  logic          can_emit;
  logic          emit_coin;
  logic          emit_accept;

  vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (coin_raw),
    .rise  (coin_rise)
  );

  vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_accept_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (accept_raw),
    .rise  (accept_rise)
  );

  assign can_emit    = (state == ST_IDLE) && ena && !fsm_busy;
  assign emit_coin   = can_emit && (pending != 3'd0);
  assign emit_accept = can_emit && (pending == 3'd0) && accept_req;

  // A coin arriving while one is emitted cancels out, even when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 3'd0;
      overflow <= 1'b0;
    end else begin
      case ({coin_rise, emit_coin})
        2'b10: begin
          if (pending == PEND_MAX) overflow <= 1'b1;
          else                     pending  <= pending + 3'd1;
        end
        2'b01:   pending <= pending - 3'd1;
        default: ;
      endcase
    end
  end

  // A press landing in the same cycle the request is consumed starts a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           accept_req <= 1'b0;
    else if (accept_rise) accept_req <= 1'b1;
    else if (emit_accept) accept_req <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      coin_pulse   <= 1'b0;
      accept_pulse <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (emit_coin) begin
            coin_pulse <= 1'b1;
            state      <= ST_PULSE;
          end else if (emit_accept) begin
            accept_pulse <= 1'b1;
            state        <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          coin_pulse   <= 1'b0;
          accept_pulse <= 1'b0;
          if (PULSE_GAP > 1) begin
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state   <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_coin_frontend.sv
// Scoreboard bench for vend_coin_frontend at default parameters.
module tb_vend_coin_frontend;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       coin_raw = 1'b0;
  logic       accept_raw = 1'b0;
  logic       fsm_busy = 1'b0;
  logic       coin_pulse;
  logic       accept_pulse;
  logic [2:0] pending;
  logic       overflow;

  vend_coin_frontend dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .coin_raw     (coin_raw),
    .accept_raw   (accept_raw),
    .fsm_busy     (fsm_busy),
    .coin_pulse   (coin_pulse),
    .accept_pulse (accept_pulse),
    .pending      (pending),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  localparam int K_COIN = 1;
  localparam int K_ACC  = 2;

  typedef struct {
    int kind;   // K_COIN or K_ACC
    int cyc;    // required edge number of the pulse, 0 = any
    int gap;    // required spacing from previous pulse, 0 = any
    int pend;   // pending seen alongside the pulse
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic prev_any = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int gap, input int pend);
    exp_t e;
    e.kind = kind; e.cyc = c; e.gap = gap; e.pend = pend;
    sb.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    int   kind;
    #1;
    if (!rst_n) begin
      prev_any = 1'b0;
    end else begin
      kind = coin_pulse ? K_COIN : K_ACC;
      if (coin_pulse && accept_pulse) chk("pulses_exclusive", 2, 1);
      if ((coin_pulse || accept_pulse) && prev_any) chk("pulse_width_cycles", 2, 1);
      if (coin_pulse || accept_pulse) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse_kind", kind, 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", kind, e.kind);
          if (e.cyc > 0) chk("pulse_cycle", cyc, e.cyc);
          if (e.gap > 0) chk("pulse_spacing", cyc - last_cyc, e.gap);
          chk("pulse_pending", int'(pending), e.pend);
        end
        last_cyc = cyc;
      end
      prev_any = coin_pulse || accept_pulse;
    end
  end

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic insert_coin();
    @(negedge clk) coin_raw = 1'b1;
    repeat (20) @(negedge clk);
    coin_raw = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  task automatic press_accept();
    @(negedge clk) accept_raw = 1'b1;
    repeat (20) @(negedge clk);
    accept_raw = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int e;

    // Reset state
    #1;
    chk("reset_coin_pulse", int'(coin_pulse), 0);
    chk("reset_accept_pulse", int'(accept_pulse), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_overflow", int'(overflow), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single coin: pulse at edge k+20, queue updated at k+19
    coin_raw = 1'b1;
    k = cyc + 1;
    push(K_COIN, k + 20, 0, 0);
    wait_cyc(k + 18);
    chk("single_pending_before", int'(pending), 0);
    wait_cyc(k + 19);
    chk("single_pending_queued", int'(pending), 1);
    wait_cyc(k + 29);
    coin_raw = 1'b0;
    repeat (25) @(negedge clk);
    drain("single_drain", 10);
    chk("single_pending_end", int'(pending), 0);

    // Glitch rejection
    coin_raw = 1'b1;
    repeat (10) @(negedge clk);
    coin_raw = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_pending", int'(pending), 0);

    // Busy queueing, coins before accept
    fsm_busy = 1'b1;
    repeat (3) insert_coin();
    press_accept();
    chk("busy_pending", int'(pending), 3);
    push(K_COIN, 0, 0, 2);
    push(K_COIN, 0, 3, 1);
    push(K_COIN, 0, 3, 0);
    push(K_ACC,  0, 3, 0);
    @(negedge clk) fsm_busy = 1'b0;
    drain("busy_drain", 40);
    chk("busy_pending_end", int'(pending), 0);

    // Overflow
    fsm_busy = 1'b1;
    repeat (7) insert_coin();
    chk("ovf_pending_full", int'(pending), 7);
    chk("ovf_not_yet", int'(overflow), 0);
    insert_coin();
    chk("ovf_pending_held", int'(pending), 7);
    chk("ovf_set", int'(overflow), 1);
    for (int i = 6; i >= 0; i--) push(K_COIN, 0, (i == 6) ? 0 : 3, i);
    @(negedge clk) fsm_busy = 1'b0;
    drain("ovf_drain", 60);
    chk("ovf_sticky", int'(overflow), 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("ovf_cleared_by_reset", int'(overflow), 0);
    @(negedge clk) rst_n = 1'b1;

    // Enable gating, then reset mid-GAP
    ena = 1'b0;
    repeat (3) insert_coin();
    repeat (10) @(negedge clk);
    chk("ena_pending_held", int'(pending), 3);
    ena = 1'b1;
    e = cyc + 1;
    push(K_COIN, e, 0, 2);
    push(K_COIN, e + 3, 3, 1);
    wait_cyc(e + 4);
    chk("ena_pending_before_reset", int'(pending), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_coin_pulse", int'(coin_pulse), 0);
    chk("rst_accept_pulse", int'(accept_pulse), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_queue_drained", sb.size(), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_pending_after", int'(pending), 0);

    // Simultaneous coin rise and emission while full
    fsm_busy = 1'b1;
    repeat (7) insert_coin();
    chk("simul_pending_full", int'(pending), 7);
    @(negedge clk) coin_raw = 1'b1;
    k = cyc + 1;
    push(K_COIN, k + 19, 0, 7);
    for (int i = 6; i >= 0; i--) push(K_COIN, 0, 3, i);
    wait_cyc(k + 18);
    fsm_busy = 1'b0;
    wait_cyc(k + 19);
    chk("simul_pending_unchanged", int'(pending), 7);
    chk("simul_no_overflow", int'(overflow), 0);
    wait_cyc(k + 21);
    coin_raw = 1'b0;
    drain("simul_drain", 60);
    chk("simul_overflow_end", int'(overflow), 0);
    chk("simul_pending_end", int'(pending), 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
